// File: rtl/jtframe_pll_rstseq.sv
// Reset sequencer for the PLL output clock domain: synchronises lock, releases
// SDRAM then game reset once lock is stable, and kicks the PLL if lock never comes.
package jtframe_pll_rstseq_pkg;
  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_STABLE = 3'd1,
    ST_SDRAM  = 3'd2,
    ST_RUN    = 3'd3,
    ST_PLLRST = 3'd4
  } state_e;
endpackage

module jtframe_pll_rstseq
  import jtframe_pll_rstseq_pkg::*;
#(
  parameter int STABLE_CNT = 1024,
  parameter int GAP        = 256,
  parameter int TIMEOUT    = 65535,
  parameter int PULSE      = 16,
  parameter int CW         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       rst_sdram,
  output logic       rst_game,
  output logic       ready,
  output logic [7:0] lost_cnt,
  output logic [2:0] st
);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sync_q;
  logic          locked_s;
  logic          lost_inc;
  logic [7:0]    lost_q, lost_d;
  logic          pll_rst_q, pll_rst_d;
  logic          rst_sdram_q, rst_sdram_d;
  logic          rst_game_q, rst_game_d;
  logic          ready_q, ready_d;

  assign locked_s = sync_q[1];

  // Loss of lock is tested before any terminal count, so it always wins a tie.
  always_comb begin
    state_d  = state_q;
    lost_inc = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (locked_s)              state_d = ST_STABLE;
        else if (cnt_q == TO_LAST) state_d = ST_PLLRST;
      end
      ST_STABLE: begin
        if (!locked_s)                 state_d = ST_WAIT;
        else if (cnt_q == STABLE_LAST) state_d = ST_SDRAM;
      end
      ST_SDRAM: begin
        if (!locked_s) begin
          state_d  = ST_WAIT;
          lost_inc = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d  = ST_WAIT;
          lost_inc = 1'b1;
        end
      end
      ST_PLLRST: begin
        if (cnt_q == PULSE_LAST) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (state_q != ST_RUN) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    lost_d = lost_q;
    if (lost_inc && (lost_q != 8'hFF)) lost_d = lost_q + 8'd1;
  end

  // Outputs decode the next state so they switch on the same edge as st.
  always_comb begin
    pll_rst_d   = 1'b0;
    rst_sdram_d = 1'b1;
    rst_game_d  = 1'b1;
    ready_d     = 1'b0;
    case (state_d)
      ST_SDRAM: rst_sdram_d = 1'b0;
      ST_RUN: begin
        rst_sdram_d = 1'b0;
        rst_game_d  = 1'b0;
        ready_d     = 1'b1;
      end
      ST_PLLRST: pll_rst_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      sync_q      <= 2'b00;
      lost_q      <= 8'd0;
      pll_rst_q   <= 1'b0;
      rst_sdram_q <= 1'b1;
      rst_game_q  <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= {sync_q[0], locked};
      lost_q      <= lost_d;
      pll_rst_q   <= pll_rst_d;
      rst_sdram_q <= rst_sdram_d;
      rst_game_q  <= rst_game_d;
      ready_q     <= ready_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign rst_sdram = rst_sdram_q;
  assign rst_game  = rst_game_q;
  assign ready     = ready_q;
  assign lost_cnt  = lost_q;
  assign st        = state_q;

endmodule

// File: tb/tb_jtframe_pll_rstseq.sv
// Directed bench for jtframe_pll_rstseq with small counts: release sequence,
// PLL kick period, dropouts, loss counter saturation, reset and illegal state.
module tb_jtframe_pll_rstseq;

  localparam int STABLE_CNT = 8;
  localparam int GAP        = 4;
  localparam int TIMEOUT    = 32;
  localparam int PULSE      = 3;
  localparam int CW         = 16;

  logic       clk, rst, locked;
  logic       pll_rst, rst_sdram, rst_game, ready;
  logic [7:0] lost_cnt;
  logic [2:0] st;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        locked;
    logic [14:0] exp;
  } vec_t;
  vec_t tbl[$];

  logic [14:0] exp_q[$];
  logic        exp_p;
  int          n;

  jtframe_pll_rstseq #(
    .STABLE_CNT(STABLE_CNT), .GAP(GAP), .TIMEOUT(TIMEOUT), .PULSE(PULSE), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked),
    .pll_rst(pll_rst), .rst_sdram(rst_sdram), .rst_game(rst_game),
    .ready(ready), .lost_cnt(lost_cnt), .st(st)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic lk);
    rst = 1'b1;
    locked = lk;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [14:0] mk(input logic [2:0] s, input logic p, input logic sd,
                                     input logic gm, input logic rd, input logic [7:0] lc);
    return {s, p, sd, gm, rd, lc};
  endfunction

  function automatic logic [14:0] outs();
    return {st, pll_rst, rst_sdram, rst_game, ready, lost_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic r, input logic l, input logic [14:0] e, input int cnt);
    repeat (cnt) tbl.push_back('{rst: r, locked: l, exp: e});
  endtask

  // sel: 0 rst_sdram low, 1 rst_game low, 2 st==SDRAM, 3 st==WAIT, 4 ready high
  task automatic wait_for(input int sel, input int limit, input string name, output int cnt);
    bit hit;
    cnt = 0;
    hit = 1'b0;
    while (!hit && cnt < limit) begin
      tick();
      cnt++;
      case (sel)
        0:       hit = (rst_sdram == 1'b0);
        1:       hit = (rst_game == 1'b0);
        2:       hit = (st == 3'd2);
        3:       hit = (st == 3'd0);
        default: hit = (ready == 1'b1);
      endcase
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: condition not reached after %0d cycles", name, cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    locked = 1'b0;
    repeat (3) tick();

    // Lock present at reset release, then lost in RUN.
    push(1'b1, 1'b1, mk(3'd0, 0, 1, 1, 0, 8'd0), 1);
    push(1'b0, 1'b1, mk(3'd0, 0, 1, 1, 0, 8'd0), 2);  // edges 0,1
    push(1'b0, 1'b1, mk(3'd1, 0, 1, 1, 0, 8'd0), 8);  // edges 2..9
    push(1'b0, 1'b1, mk(3'd2, 0, 0, 1, 0, 8'd0), 4);  // edges 10..13
    push(1'b0, 1'b1, mk(3'd3, 0, 0, 0, 1, 8'd0), 2);  // edges 14,15
    push(1'b0, 1'b0, mk(3'd3, 0, 0, 0, 1, 8'd0), 2);  // edges 16,17
    push(1'b0, 1'b0, mk(3'd0, 0, 1, 1, 0, 8'd1), 1);  // edge 18
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      locked = tbl[i].locked;
      tick();
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Relock repeats the 8/4 release spacing.
    locked = 1'b1;
    wait_for(0, 40, "relock_sdram", n);
    check("relock_sdram_edges", n, 11);
    wait_for(1, 20, "relock_game", n);
    check("relock_game_edges", n, GAP);
    check("relock_run", outs(), mk(3'd3, 0, 0, 0, 1, 8'd1));

    // No lock: WAIT 32 / PLLRST 3; lock pulses that only land in PLLRST are ignored.
    do_reset(1'b0);
    for (int e = 0; e < 105; e++) begin
      locked = (((e + 5) % 35) < 3) ? 1'b1 : 1'b0;
      tick();
      exp_p = (e >= 31) && (((e - 31) % 35) < 3);
      check($sformatf("kick_e%0d", e), {st, pll_rst}, {(exp_p ? 3'd4 : 3'd0), exp_p});
    end
    locked = 1'b0;

    // Single-cycle dropout in STABLE restarts from WAIT.
    do_reset(1'b1);
    repeat (3) tick();
    check("dropout_stable", st, 3'd1);
    tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    check("dropout_still_stable", st, 3'd1);
    tick();
    check("dropout_wait", outs(), mk(3'd0, 0, 1, 1, 0, 8'd0));
    wait_for(2, 40, "dropout_restab", n);
    check("dropout_restab_edges", n, STABLE_CNT + 1);
    check("dropout_sdram", outs(), mk(3'd2, 0, 0, 1, 0, 8'd0));

    // Lock loss coinciding with the SDRAM terminal count.
    do_reset(1'b1);
    wait_for(2, 40, "tie_sdram", n);
    check("tie_sdram_edges", n, 11);
    tick();
    locked = 1'b0;
    tick();
    tick();
    check("tie_pre", st, 3'd2);
    tick();
    check("tie_loss_wins", outs(), mk(3'd0, 0, 1, 1, 0, 8'd1));

    // Repeated loss in SDRAM saturates the counter at 255.
    do_reset(1'b0);
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back((i + 1 > 255) ? 15'd255 : 15'(i + 1));
      locked = 1'b1;
      wait_for(2, 50, "sat_sdram", n);
      locked = 1'b0;
      wait_for(3, 10, "sat_wait", n);
      check($sformatf("sat_lost%0d", i), lost_cnt, exp_q.pop_front());
    end

    // Reset mid-RUN.
    locked = 1'b1;
    wait_for(4, 50, "rst_run", n);
    check("rst_pre", outs(), mk(3'd3, 0, 0, 0, 1, 8'd255));
    rst = 1'b1;
    tick();
    check("rst_mid_run", outs(), mk(3'd0, 0, 1, 1, 0, 8'd0));
    rst = 1'b0;

    // Illegal state encoding returns to WAIT.
    wait_for(4, 50, "illegal_run", n);
    force dut.state_q = jtframe_pll_rstseq_pkg::state_e'(3'd6);
    #1;
    check("illegal_forced", st, 3'd6);
    release dut.state_q;
    tick();
    check("illegal_to_wait", outs(), mk(3'd0, 0, 1, 1, 0, 8'd0));
    tick();
    check("illegal_then_stable", outs(), mk(3'd1, 0, 1, 1, 0, 8'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtframe_pll_rstseq.md
# jtframe_pll_rstseq

Reset sequencer on the consuming side of a frame PLL. It runs on a PLL output clock and synchronises the asynchronous `locked` flag. Once lock has been continuously stable, it releases the SDRAM reset and then the game reset in order. If lock never arrives, it pulses the PLL reset input. Every loss of lock after release re-asserts both resets and is counted for the debug/OSD status path.

## Interface
Parameters:
- `STABLE_CNT`, default 1024: cycles `locked_s` must stay high before SDRAM reset release (≥2).
- `GAP`, default 256: cycles between SDRAM reset release and game reset release (≥1).
- `TIMEOUT`, default 65535: cycles without lock before a PLL reset pulse (≥2).
- `PULSE`, default 16: length of the `pll_rst` pulse in cycles (≥1).
- `CW`, default 16: internal counter width; must hold max(STABLE_CNT, GAP, TIMEOUT, PULSE).

Ports:
- `clk`, in, 1: PLL output clock (outclk_0 domain).
- `rst`, in, 1: synchronous, active-high reset.
- `locked`, in, 1: PLL lock flag, asynchronous to `clk`.
- `pll_rst`, out, 1: reset request to the PLL `rst` input.
- `rst_sdram`, out, 1: active-high reset for the SDRAM controller.
- `rst_game`, out, 1: active-high reset for game logic.
- `ready`, out, 1: high only in RUN.
- `lost_cnt`, out, 8: count of lock losses from SDRAM/RUN, saturating.
- `st`, out, 3: current state encoding, for debug.

## Operation
- `locked` passes through a 2-FF synchroniser; the second flop output is `locked_s`. All decisions use `locked_s`.
- One counter `cnt` of width `CW` is cleared on every state change.
- States and `st` encoding:
  - WAIT = 0: if `locked_s`, go to STABLE. Otherwise `cnt++`; when `cnt == TIMEOUT-1`, go to PLLRST.
  - STABLE = 1: if `!locked_s`, go to WAIT. Otherwise `cnt++`; when `cnt == STABLE_CNT-1`, go to SDRAM.
  - SDRAM = 2: if `!locked_s`, go to WAIT and increment `lost_cnt`. Otherwise `cnt++`; when `cnt == GAP-1`, go to RUN.
  - RUN = 3: if `!locked_s`, go to WAIT and increment `lost_cnt`. Otherwise stay.
  - PLLRST = 4: `locked_s` is ignored. `cnt++`; when `cnt == PULSE-1`, go to WAIT.
  - Encodings 5–7 are illegal and return to WAIT on the next edge.
- Output decode:
  - `rst_sdram` = 1 in WAIT, STABLE, PLLRST.
  - `rst_game` = 1 in every state except RUN.
  - `ready` = 1 only in RUN.
  - `pll_rst` = 1 only in PLLRST.
- All outputs are registered and computed from the next state, so each output changes on the same edge as `st`. Outputs are glitch-free.
- `lost_cnt` saturates at 255 and clears only on `rst`.

## Timing
- Reset values while `rst` is high (applied on the next edge):
  - state WAIT, `cnt` = 0, both synchroniser flops 0.
  - `rst_sdram` = 1, `rst_game` = 1, `ready` = 0, `pll_rst` = 0, `lost_cnt` = 0, `st` = 0.
- `rst` asserted mid-operation in any state forces these values on the next edge; it overrides all transitions.
- `locked` to `locked_s` takes 2 edges. The state reacts on the 3rd edge.
- Lock loss in RUN: `rst_sdram` and `rst_game` rise, and `ready` falls, 3 edges after `locked` falls.
- Stable relock: `rst_sdram` falls `3 + STABLE_CNT - 1` edges after `locked` is first sampled high. `rst_game` falls `GAP` edges after `rst_sdram`.
- A single-cycle dropout of `locked_s` in STABLE restarts stabilisation from WAIT. `lost_cnt` is unchanged.
- Without lock, the cycle is WAIT for `TIMEOUT` cycles, then PLLRST for `PULSE` cycles, repeating.
- When loss of lock and the terminal count occur in the same cycle, loss of lock wins.

## Test plan
Bench parameters: STABLE_CNT=8, GAP=4, TIMEOUT=32, PULSE=3.
- `locked` = 1 before `rst` falls -> `st` 1 after edge 2, `rst_sdram` 0 after edge 10, `rst_game` 0 and `ready` 1 after edge 14, `pll_rst` never 1.
- `locked` held 0 -> `pll_rst` = 1 for exactly 3 cycles starting after edge 31, then `st` = 0; the period repeats every 35 cycles. `locked` toggling during PLLRST has no effect.
- `locked` low for 1 cycle during STABLE -> back to WAIT, full 8-cycle stabilisation restarts, `lost_cnt` = 0, `rst_sdram` stays 1.
- In RUN, drop `locked` -> 3 edges later `rst_sdram` = `rst_game` = 1, `ready` = 0, `lost_cnt` = 1. On relock, the release sequence repeats with the same 8/4 spacing.
- Drop lock in SDRAM 300 times -> `lost_cnt` reaches 255 and stays there. `rst` pulse mid-RUN -> all outputs take their reset values on the next edge and `lost_cnt` = 0.
- Force `st` = 6 via the bench -> WAIT on the next edge with reset-valued outputs.
